// File: rtl/router_out_reader.sv
// Output-channel reader for the packet router: pops one packet from the channel
// FIFO, forwards it downstream, checks its parity and address, and counts packets and errors.
module router_out_reader #(
  parameter logic [1:0] CH_ID = 2'd0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       vld_out,
  input  logic [7:0] data_out,
  input  logic       soft_reset,
  input  logic       sink_ready,
  output logic       read_enb,
  output logic       pkt_valid,
  output logic       pkt_sop,
  output logic       pkt_eop,
  output logic [7:0] pkt_data,
  output logic       pkt_done,
  output logic       pkt_abort,
  output logic       parity_err,
  output logic       addr_err,
  output logic [7:0] pkt_count,
  output logic [7:0] err_count
);

  localparam int unsigned REM_W = 7;

  typedef enum logic [1:0] {IDLE, HDR_WAIT, READ, LAST} state_t;

  state_t           state;
  state_t           next_state;
  logic [REM_W-1:0] remaining;
  logic [7:0]       parity_acc;
  logic             parity_bad;

  assign parity_bad = (parity_acc != data_out);
  assign pkt_data   = pkt_valid ? data_out : 8'h00;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next state and the FIFO pop request; the popped byte shows up one cycle later.
  always_comb begin
    next_state = state;
    read_enb   = 1'b0;
    case (state)
      IDLE: begin
        read_enb = vld_out & sink_ready;
        if (read_enb) next_state = HDR_WAIT;
      end
      HDR_WAIT: begin
        if (pkt_valid) next_state = READ;
      end
      READ: begin
        read_enb = vld_out & sink_ready & (remaining != '0);
        if (read_enb && (remaining == REM_W'(1))) next_state = LAST;
      end
      LAST: begin
        if (pkt_valid) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (soft_reset) next_state = IDLE;
    if (reset)      read_enb   = 1'b0;
  end

  // Byte tagging, parity/address checking and counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pkt_valid  <= 1'b0;
      pkt_sop    <= 1'b0;
      pkt_eop    <= 1'b0;
      pkt_done   <= 1'b0;
      pkt_abort  <= 1'b0;
      parity_err <= 1'b0;
      addr_err   <= 1'b0;
      pkt_count  <= 8'h00;
      err_count  <= 8'h00;
      remaining  <= '0;
      parity_acc <= 8'h00;
    end else begin
      pkt_valid <= read_enb & ~soft_reset;
      pkt_sop   <= read_enb & ~soft_reset & (state == IDLE);
      pkt_eop   <= read_enb & ~soft_reset & (state == READ) & (remaining == REM_W'(1));
      pkt_done  <= 1'b0;
      pkt_abort <= soft_reset & (state != IDLE);
      if (soft_reset) begin
        remaining  <= '0;
        parity_acc <= 8'h00;
      end else begin
        case (state)
          HDR_WAIT: begin
            if (pkt_valid) begin
              remaining  <= REM_W'(data_out[7:2]) + REM_W'(1);
              parity_acc <= data_out;
              addr_err   <= (data_out[1:0] != CH_ID);
              parity_err <= 1'b0;
            end
          end
          READ: begin
            if (read_enb)  remaining  <= remaining - REM_W'(1);
            if (pkt_valid) parity_acc <= parity_acc ^ data_out;
          end
          LAST: begin
            if (pkt_valid) begin
              pkt_done   <= 1'b1;
              parity_err <= parity_bad;
              pkt_count  <= pkt_count + 8'd1;
              if ((parity_bad || addr_err) && (err_count != 8'hFF))
                err_count <= err_count + 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_router_out_reader.sv
// Directed bench for router_out_reader: a FIFO model feeds packets, a negedge
// monitor collects forwarded bytes and pulses, and each task checks one feature.
module tb_router_out_reader;

  logic       clock = 1'b0;
  logic       reset;
  logic       vld_out = 1'b0;
  logic [7:0] data_out = 8'h00;
  logic       soft_reset;
  logic       sink_ready;
  logic       read_enb, pkt_valid, pkt_sop, pkt_eop, pkt_done, pkt_abort;
  logic       parity_err, addr_err;
  logic [7:0] pkt_data, pkt_count, err_count;

  router_out_reader #(.CH_ID(2'd0)) dut (
    .clock(clock), .reset(reset), .vld_out(vld_out), .data_out(data_out),
    .soft_reset(soft_reset), .sink_ready(sink_ready), .read_enb(read_enb),
    .pkt_valid(pkt_valid), .pkt_sop(pkt_sop), .pkt_eop(pkt_eop),
    .pkt_data(pkt_data), .pkt_done(pkt_done), .pkt_abort(pkt_abort),
    .parity_err(parity_err), .addr_err(addr_err),
    .pkt_count(pkt_count), .err_count(err_count)
  );

  always #5 clock = ~clock;

  logic [7:0] fifo[$];
  logic [7:0] exp_q[$];
  logic [7:0] rx[$];
  logic       re_trace[$];
  logic       vld_en = 1'b0;
  logic       trace_on = 1'b0;
  int compared = 0, mismatched = 0;
  int n_reads = 0, n_done = 0, n_abort = 0, n_both = 0, n_sop = 0;
  logic perr_at_done = 1'b0, aerr_at_done = 1'b0;

  // Channel FIFO model: pop on read_enb, data one cycle later.
  always @(posedge clock)
    if (read_enb && fifo.size() != 0) data_out <= fifo.pop_front();

  always begin
    @(posedge clock);
    #2;
    vld_out = vld_en && (fifo.size() != 0);
  end

  always @(negedge clock) begin
    if (pkt_valid) rx.push_back(pkt_data);
    if (read_enb) n_reads++;
    if (pkt_sop) n_sop++;
    if (pkt_abort) n_abort++;
    if (pkt_done && pkt_abort) n_both++;
    if (pkt_done) begin
      n_done++;
      perr_at_done = parity_err;
      aerr_at_done = addr_err;
    end
    if (trace_on) re_trace.push_back(read_enb);
  end

  function automatic bit rx_matches();
    if (rx.size() != exp_q.size()) return 1'b0;
    foreach (rx[i]) if (rx[i] !== exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo.push_back(b);
    exp_q.push_back(b);
  endtask

  // Header, len payload bytes base+i, parity (optionally corrupted).
  task automatic push_pkt(input logic [7:0] hdr, input logic [7:0] base, input bit bad);
    logic [7:0] p;
    logic [7:0] b;
    p = hdr;
    push_byte(hdr);
    for (int i = 0; i < int'(hdr[7:2]); i++) begin
      b = base + 8'(i);
      push_byte(b);
      p = p ^ b;
    end
    if (bad) p = p ^ 8'h5A;
    push_byte(p);
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int k;
    k = 0;
    while (n_done < target && k < budget) begin
      @(negedge clock); #1;
      k++;
    end
    if (n_done < target) begin
      compared++; mismatched++;
      $display("FAIL %s: timeout, pkt_done seen %0d, required %0d", name, n_done, target);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; soft_reset = 1'b0; sink_ready = 1'b1; vld_en = 1'b1;
    fifo.push_back(8'h55);
    tick(4);
    @(negedge clock);
    compared++;
    if ({read_enb, pkt_valid, pkt_sop, pkt_eop, pkt_done, pkt_abort, parity_err, addr_err} !== 8'h00) begin
      mismatched++;
      $display("FAIL reset_flags: got %b required 00000000",
               {read_enb, pkt_valid, pkt_sop, pkt_eop, pkt_done, pkt_abort, parity_err, addr_err});
    end
    compared++;
    if (pkt_count !== 8'h00) begin mismatched++; $display("FAIL reset_pkt_count: got %0d required 0", pkt_count); end
    compared++;
    if (err_count !== 8'h00) begin mismatched++; $display("FAIL reset_err_count: got %0d required 0", err_count); end
    compared++;
    if (pkt_data !== 8'h00) begin mismatched++; $display("FAIL reset_pkt_data: got %h required 00", pkt_data); end
    @(posedge clock); #1;
    fifo.delete();
    reset = 1'b0;
    tick(3);
    compared++;
    if (read_enb !== 1'b0 || n_reads != 0) begin
      mismatched++; $display("FAIL post_reset_idle: read_enb %b reads %0d required 0/0", read_enb, n_reads);
    end
  endtask

  task automatic test_basic();
    int r0, d0, i0;
    logic [6:0] tr;
    r0 = n_reads; d0 = n_done;
    rx.delete(); exp_q.delete(); re_trace.delete();
    trace_on = 1'b1;
    push_byte(8'h0C); push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h0C);
    wait_done(d0 + 1, 50, "basic_done");
    trace_on = 1'b0;
    i0 = -1;
    for (int i = 0; i < re_trace.size(); i++) if (re_trace[i] === 1'b1) begin i0 = i; break; end
    tr = 7'h00;
    if (i0 >= 0 && i0 + 7 <= re_trace.size())
      for (int k = 0; k < 7; k++) tr[6-k] = re_trace[i0+k];
    compared++;
    if (i0 < 0 || tr !== 7'b1011110) begin mismatched++; $display("FAIL basic_read_pattern: got %b required 1011110", tr); end
    compared++;
    if (n_reads - r0 != 5) begin mismatched++; $display("FAIL basic_reads: got %0d required 5", n_reads - r0); end
    compared++;
    if (!rx_matches()) begin mismatched++; $display("FAIL basic_bytes: got %0d bytes required %0d in order", rx.size(), exp_q.size()); end
    compared++;
    if (perr_at_done !== 1'b0 || aerr_at_done !== 1'b0) begin
      mismatched++; $display("FAIL basic_flags: parity_err %b addr_err %b required 0 0", perr_at_done, aerr_at_done);
    end
    compared++;
    if (pkt_count !== 8'd1 || err_count !== 8'd0) begin
      mismatched++; $display("FAIL basic_counts: pkt %0d err %0d required 1 0", pkt_count, err_count);
    end
    tick(3);
    compared++;
    if (n_done - d0 != 1) begin mismatched++; $display("FAIL basic_done_once: got %0d required 1", n_done - d0); end
  endtask

  task automatic test_parity_err();
    int d0, s0, k;
    d0 = n_done;
    push_byte(8'h0C); push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h0D);
    wait_done(d0 + 1, 50, "perr_done");
    compared++;
    if (perr_at_done !== 1'b1) begin mismatched++; $display("FAIL perr_flag: got %b required 1", perr_at_done); end
    compared++;
    if (err_count !== 8'd1 || pkt_count !== 8'd2) begin
      mismatched++; $display("FAIL perr_counts: err %0d pkt %0d required 1 2", err_count, pkt_count);
    end
    tick(2);
    s0 = n_sop;
    push_byte(8'h0C); push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h0C);
    k = 0;
    while (n_sop == s0 && k < 20) begin @(negedge clock); #1; k++; end
    compared++;
    if (n_sop == s0 || parity_err !== 1'b1) begin
      mismatched++; $display("FAIL perr_hold_to_header: parity_err %b sop %0d required 1 1", parity_err, n_sop - s0);
    end
    @(negedge clock); #1;
    compared++;
    if (parity_err !== 1'b0) begin mismatched++; $display("FAIL perr_clear_at_header: got %b required 0", parity_err); end
    wait_done(d0 + 2, 50, "perr_clean_done");
    compared++;
    if (perr_at_done !== 1'b0 || err_count !== 8'd1 || pkt_count !== 8'd3) begin
      mismatched++; $display("FAIL perr_clean: perr %b err %0d pkt %0d required 0 1 3", perr_at_done, err_count, pkt_count);
    end
    tick(2);
  endtask

  task automatic test_addr_err();
    int r0, d0;
    r0 = n_reads; d0 = n_done;
    push_byte(8'h01); push_byte(8'h01);
    wait_done(d0 + 1, 50, "addr_done");
    tick(2);
    compared++;
    if (n_reads - r0 != 2) begin mismatched++; $display("FAIL addr_reads: got %0d required 2", n_reads - r0); end
    compared++;
    if (aerr_at_done !== 1'b1 || perr_at_done !== 1'b0) begin
      mismatched++; $display("FAIL addr_flags: addr_err %b parity_err %b required 1 0", aerr_at_done, perr_at_done);
    end
    compared++;
    if (err_count !== 8'd2 || pkt_count !== 8'd4) begin
      mismatched++; $display("FAIL addr_counts: err %0d pkt %0d required 2 4", err_count, pkt_count);
    end
  endtask

  task automatic test_stall_abort();
    int r0, d0, a0, rs, k;
    r0 = n_reads; d0 = n_done; a0 = n_abort;
    push_byte(8'h0C); push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h0C);
    k = 0;
    while (n_reads < r0 + 2 && k < 20) begin @(negedge clock); #1; k++; end
    @(posedge clock); #1;
    sink_ready = 1'b0;
    rs = n_reads;
    tick(30);
    compared++;
    if (rs != r0 + 2 || n_reads != rs) begin
      mismatched++; $display("FAIL stall_no_reads: reads %0d required %0d", n_reads - r0, 2);
    end
    soft_reset = 1'b1;
    fifo.delete();
    sink_ready = 1'b1;
    tick(1);
    soft_reset = 1'b0;
    tick(4);
    compared++;
    if (n_abort - a0 != 1) begin mismatched++; $display("FAIL abort_pulse: got %0d cycles required 1", n_abort - a0); end
    compared++;
    if (n_done != d0 || pkt_count !== 8'd4 || err_count !== 8'd2) begin
      mismatched++; $display("FAIL abort_counts: done %0d pkt %0d err %0d required 0 4 2", n_done - d0, pkt_count, err_count);
    end
    compared++;
    if (n_reads != rs || read_enb !== 1'b0) begin mismatched++; $display("FAIL abort_read_enb: reads %0d required 0", n_reads - rs); end
    rx.delete(); exp_q.delete();
    push_byte(8'h04); push_byte(8'hAA); push_byte(8'hAE);
    wait_done(d0 + 1, 50, "abort_recover_done");
    compared++;
    if (!rx_matches() || perr_at_done !== 1'b0 || pkt_count !== 8'd5) begin
      mismatched++; $display("FAIL abort_recover: bytes %0d perr %b pkt %0d required 3 0 5", rx.size(), perr_at_done, pkt_count);
    end
    tick(2);
  endtask

  task automatic test_toggle();
    int r0, d0, k;
    r0 = n_reads; d0 = n_done;
    rx.delete(); exp_q.delete();
    push_pkt(8'hFC, 8'h40, 1'b0);
    k = 0;
    while (n_done == d0 && k < 600) begin
      @(posedge clock); #1;
      vld_en = ~vld_en;
      k++;
    end
    vld_en = 1'b1;
    tick(3);
    compared++;
    if (n_done - d0 != 1) begin mismatched++; $display("FAIL toggle_done: got %0d required 1", n_done - d0); end
    compared++;
    if (!rx_matches() || rx.size() != 65) begin mismatched++; $display("FAIL toggle_bytes: got %0d bytes required 65 in order", rx.size()); end
    compared++;
    if (n_reads - r0 != 65) begin mismatched++; $display("FAIL toggle_reads: got %0d required 65", n_reads - r0); end
    compared++;
    if (perr_at_done !== 1'b0 || pkt_count !== 8'd6) begin
      mismatched++; $display("FAIL toggle_status: perr %b pkt %0d required 0 6", perr_at_done, pkt_count);
    end
  endtask

  task automatic test_back_to_back();
    int d0;
    d0 = n_done;
    repeat (249) push_pkt(8'h00, 8'h00, 1'b0);
    wait_done(d0 + 249, 249 * 4 + 50, "b2b_good_a");
    compared++;
    if (pkt_count !== 8'd255) begin mismatched++; $display("FAIL b2b_count_255: got %0d required 255", pkt_count); end
    push_pkt(8'h00, 8'h00, 1'b0);
    wait_done(d0 + 250, 50, "b2b_good_b");
    compared++;
    if (pkt_count !== 8'd0) begin mismatched++; $display("FAIL b2b_wrap: got %0d required 0", pkt_count); end
    repeat (6) push_pkt(8'h00, 8'h00, 1'b0);
    wait_done(d0 + 256, 80, "b2b_good_c");
    compared++;
    if (pkt_count !== 8'd6 || err_count !== 8'd2) begin
      mismatched++; $display("FAIL b2b_after_256: pkt %0d err %0d required 6 2", pkt_count, err_count);
    end
    repeat (253) push_pkt(8'h00, 8'h00, 1'b1);
    wait_done(d0 + 509, 253 * 4 + 50, "b2b_bad_a");
    compared++;
    if (err_count !== 8'd255) begin mismatched++; $display("FAIL err_reach_255: got %0d required 255", err_count); end
    repeat (47) push_pkt(8'h00, 8'h00, 1'b1);
    wait_done(d0 + 556, 47 * 4 + 50, "b2b_bad_b");
    compared++;
    if (err_count !== 8'd255 || pkt_count !== 8'd50) begin
      mismatched++; $display("FAIL err_saturate: err %0d pkt %0d required 255 50", err_count, pkt_count);
    end
    compared++;
    if (n_both != 0) begin mismatched++; $display("FAIL done_abort_overlap: got %0d required 0", n_both); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity_err();
    test_addr_err();
    test_stall_abort();
    test_toggle();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
